cache_arbiter: RTL and testbench

Arbitrates the single physical-memory line port between the instruction cache and the data cache of the pipelined RV32I core. Sits between both cache miss/writeback interfaces and main memory. Captures one request at a time, holds the memory command stable until `pmem_resp`, and routes the response back to the owning cache. Ties are broken round-robin so neither pipeline stage starves.

---
 rtl/cache_arbiter.sv | 119 +++++++++++
 tb/tb_cache_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares the single physical-memory line port between the
// I-cache and the D-cache. One transaction is captured at a time, and its
// memory command is held stable until pmem_resp. The response is routed back
// to the owning cache in the same cycle. Ties go to the side that was not
// granted last, so neither side starves.
module cache_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache side
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  // D-cache side
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  // physical memory side
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;
  localparam logic [1:0] RECOVER = 2'd3;

  logic [1:0]        r_state;
  logic              r_last_d;
  logic              r_read;
  logic              r_write;
  logic [ADDR_W-1:0] r_address;
  logic [LINE_W-1:0] r_wdata;

  logic w_i_pend;
  logic w_d_pend;
  logic w_grant_i;
  logic w_grant_d;

  // Grant decision in IDLE: a lone requester wins; on a tie the side that
  // was not granted last wins.
  always_comb begin
    w_i_pend  = i_read;
    w_d_pend  = d_read | d_write;
    w_grant_i = w_i_pend & (~w_d_pend | r_last_d);
    w_grant_d = w_d_pend & (~w_i_pend | ~r_last_d);
  end

  // State machine plus the captured memory command. The memory outputs come
  // only from these registers, so requester changes mid-service have no effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last_d  <= 1'b0;
      r_read    <= 1'b0;
      r_write   <= 1'b0;
      r_address <= '0;
      r_wdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_i) begin
            r_state   <= SERVE_I;
            r_last_d  <= 1'b0;
            r_read    <= 1'b1;
            r_write   <= 1'b0;
            r_address <= i_address;
            r_wdata   <= '0;
          end else if (w_grant_d) begin
            // a simultaneous read and write is illegal; the write wins
            r_state   <= SERVE_D;
            r_last_d  <= 1'b1;
            r_read    <= ~d_write;
            r_write   <= d_write;
            r_address <= d_address;
            r_wdata   <= d_wdata;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            r_state <= RECOVER;
            r_read  <= 1'b0;
            r_write <= 1'b0;
          end
        end
        RECOVER: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Responses are combinational from pmem_resp, qualified by the owner state.
  // Read data is a plain pass-through; only the resp pulse qualifies it.
  always_comb begin
    i_resp       = (r_state == SERVE_I) & pmem_resp;
    d_resp       = (r_state == SERVE_D) & pmem_resp;
    i_rdata      = pmem_rdata;
    d_rdata      = pmem_rdata;
    pmem_read    = r_read;
    pmem_write   = r_write;
    pmem_address = r_address;
    pmem_wdata   = r_wdata;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: self-checking bench for cache_arbiter. Directed scenarios
// plus randomized traffic compared against a round-robin reference model that
// only tracks who is pending and who was served last.
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          iRead = 1'b0;
  logic [AW-1:0] iAddress = '0;
  logic [LW-1:0] iRdata;
  logic          iResp;
  logic          dRead = 1'b0;
  logic          dWrite = 1'b0;
  logic [AW-1:0] dAddress = '0;
  logic [LW-1:0] dWdata = '0;
  logic [LW-1:0] dRdata;
  logic          dResp;
  logic          pmemRead;
  logic          pmemWrite;
  logic [AW-1:0] pmemAddress;
  logic [LW-1:0] pmemWdata;
  logic [LW-1:0] pmemRdata = '0;
  logic          pmemResp = 1'b0;

  int checks = 0;
  int errors = 0;

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .i_read(iRead), .i_address(iAddress), .i_rdata(iRdata), .i_resp(iResp),
    .d_read(dRead), .d_write(dWrite), .d_address(dAddress), .d_wdata(dWdata),
    .d_rdata(dRdata), .d_resp(dResp),
    .pmem_read(pmemRead), .pmem_write(pmemWrite), .pmem_address(pmemAddress),
    .pmem_wdata(pmemWdata), .pmem_rdata(pmemRdata), .pmem_resp(pmemResp)
  );

  // free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // hard time limit so the bench can never hang
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [LW-1:0] randLine();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task clearInputs;
    iRead = 1'b0; dRead = 1'b0; dWrite = 1'b0; pmemResp = 1'b0;
  endtask

  task doReset;
    @(negedge clk);
    rst = 1'b1;
    clearInputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for a memory command; cycles counts negedges from the call.
  task waitCommand(output bit seen, output int cycles);
    seen = 1'b0;
    cycles = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      cycles++;
      if (pmemRead || pmemWrite) seen = 1'b1;
    end
  endtask

  task test_reset;
    #2;
    iRead = 1'b1; pmemResp = 1'b1;
    checks++;
    if ({pmemRead, pmemWrite, iResp, dResp} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b want 0000", {pmemRead, pmemWrite, iResp, dResp});
    end
    checks++;
    if (pmemAddress !== '0 || pmemWdata !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: addr %h wdata %h want zeros", pmemAddress, pmemWdata);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (pmemRead !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold: pmem_read %b want 0", pmemRead);
    end
    clearInputs();
  endtask

  task test_lone_i_read;
    bit seen; int cycles; int resps;
    logic [LW-1:0] line;
    line = {32{8'hA5}};
    resps = 0;
    doReset();
    iRead = 1'b1; iAddress = 32'h0000_1000;
    waitCommand(seen, cycles);
    checks++;
    if (!seen || cycles != 1) begin
      errors++;
      $display("[TB] FAIL i_grant_latency: seen %0d cycles %0d want 1", seen, cycles);
    end
    checks++;
    if ({pmemRead, pmemWrite, pmemAddress} !== {2'b10, 32'h0000_1000}) begin
      errors++;
      $display("[TB] FAIL i_cmd: rd %b wr %b addr %h want 1 0 00001000", pmemRead, pmemWrite, pmemAddress);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (iResp || dResp) resps++;
      checks++;
      if (pmemRead !== 1'b1 || pmemAddress !== 32'h0000_1000) begin
        errors++;
        $display("[TB] FAIL i_hold: rd %b addr %h want 1 00001000", pmemRead, pmemAddress);
      end
    end
    @(negedge clk);
    pmemRdata = line; pmemResp = 1'b1;
    #1;
    checks++;
    if ({iResp, dResp, pmemRead} !== 3'b101 || iRdata !== line) begin
      errors++;
      $display("[TB] FAIL i_resp: iresp %b dresp %b rd %b data %h want 1 0 1 a5..", iResp, dResp, pmemRead, iRdata);
    end
    @(negedge clk);
    pmemResp = 1'b0; iRead = 1'b0;
    #1;
    checks++;
    if ({pmemRead, iResp, dResp} !== 3'b000 || resps != 0) begin
      errors++;
      $display("[TB] FAIL i_after: rd %b iresp %b dresp %b early %0d want 0 0 0 0", pmemRead, iResp, dResp, resps);
    end
  endtask

  task test_lone_d_write;
    bit seen; int cycles; bit sawRead;
    logic [LW-1:0] wd;
    wd = {16{16'h1234}};
    sawRead = 1'b0;
    doReset();
    dWrite = 1'b1; dAddress = 32'h8000_0040; dWdata = wd;
    waitCommand(seen, cycles);
    checks++;
    if (!seen || {pmemWrite, pmemAddress} !== {1'b1, 32'h8000_0040} || pmemWdata !== wd) begin
      errors++;
      $display("[TB] FAIL d_write_cmd: wr %b addr %h wdata %h want 1 80000040 1234..", pmemWrite, pmemAddress, pmemWdata);
    end
    for (int k = 0; k < 3; k++) begin
      if (pmemRead) sawRead = 1'b1;
      @(negedge clk);
    end
    pmemResp = 1'b1;
    #1;
    if (pmemRead) sawRead = 1'b1;
    checks++;
    if ({dResp, iResp} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL d_write_resp: dresp %b iresp %b want 1 0", dResp, iResp);
    end
    @(negedge clk);
    pmemResp = 1'b0; dWrite = 1'b0;
    #1;
    if (pmemRead) sawRead = 1'b1;
    checks++;
    if (sawRead || dResp !== 1'b0 || pmemWrite !== 1'b0) begin
      errors++;
      $display("[TB] FAIL d_write_clean: sawread %0d dresp %b wr %b want 0 0 0", sawRead, dResp, pmemWrite);
    end
  endtask

  task test_both_from_reset;
    bit seen; int cycles;
    doReset();
    iRead = 1'b1; iAddress = 32'h0000_2000;
    dRead = 1'b1; dAddress = 32'h0000_3000;
    waitCommand(seen, cycles);
    checks++;
    if (!seen || pmemAddress !== 32'h0000_3000 || pmemRead !== 1'b1) begin
      errors++;
      $display("[TB] FAIL both_first_d: rd %b addr %h want 1 00003000", pmemRead, pmemAddress);
    end
    pmemResp = 1'b1;
    #1;
    checks++;
    if ({dResp, iResp} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL both_d_resp: dresp %b iresp %b want 1 0", dResp, iResp);
    end
    @(negedge clk);
    pmemResp = 1'b0; dRead = 1'b0;
    waitCommand(seen, cycles);
    checks++;
    if (!seen || cycles != 2 || pmemAddress !== 32'h0000_2000) begin
      errors++;
      $display("[TB] FAIL both_turnaround: seen %0d cycles_after_resp %0d addr %h want 3 00002000", seen, cycles + 1, pmemAddress);
    end
    pmemResp = 1'b1;
    #1;
    checks++;
    if ({iResp, dResp} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL both_i_resp: iresp %b dresp %b want 1 0", iResp, dResp);
    end
    @(negedge clk);
    clearInputs();
  endtask

  task test_back_to_back;
    bit seen; int cycles;
    bit expD [4];
    expD = '{1'b1, 1'b0, 1'b1, 1'b0};
    doReset();
    iRead = 1'b1; iAddress = 32'h0000_0A00;
    dRead = 1'b1; dAddress = 32'h0000_0D00;
    for (int n = 0; n < 4; n++) begin
      waitCommand(seen, cycles);
      checks++;
      if (!seen || pmemAddress !== (expD[n] ? 32'h0000_0D00 : 32'h0000_0A00)) begin
        errors++;
        $display("[TB] FAIL b2b_order_%0d: seen %0d addr %h want D=%0d", n, seen, pmemAddress, expD[n]);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pmemResp = 1'b1;
      #1;
      checks++;
      if ({dResp, iResp} !== {expD[n], ~expD[n]}) begin
        errors++;
        $display("[TB] FAIL b2b_resp_%0d: dresp %b iresp %b want D=%0d", n, dResp, iResp, expD[n]);
      end
      @(negedge clk);
      pmemResp = 1'b0;
    end
    clearInputs();
  endtask

  task test_addr_change;
    bit seen; int cycles;
    doReset();
    dRead = 1'b1; dAddress = 32'hCAFE_0100;
    waitCommand(seen, cycles);
    for (int k = 0; k < 3; k++) begin
      dAddress = $urandom; iAddress = $urandom; dWdata = randLine();
      @(negedge clk);
      checks++;
      if (!seen || pmemAddress !== 32'hCAFE_0100 || pmemRead !== 1'b1) begin
        errors++;
        $display("[TB] FAIL addr_stable_%0d: rd %b addr %h want 1 cafe0100", k, pmemRead, pmemAddress);
      end
    end
    pmemResp = 1'b1;
    @(negedge clk);
    clearInputs();
  endtask

  task test_reset_mid_serve;
    bit seen; int cycles;
    doReset();
    dWrite = 1'b1; dAddress = 32'h0000_4440; dWdata = randLine();
    iRead = 1'b1; iAddress = 32'h0000_5550;
    waitCommand(seen, cycles);
    pmemResp = 1'b1;
    #1;
    checks++;
    if (!seen || dResp !== 1'b1 || pmemWrite !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_pre: dresp %b wr %b want 1 1", dResp, pmemWrite);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({pmemRead, pmemWrite, iResp, dResp} !== 4'b0000 || pmemAddress !== '0) begin
      errors++;
      $display("[TB] FAIL rst_async: ctrl %b addr %h want 0000 0", {pmemRead, pmemWrite, iResp, dResp}, pmemAddress);
    end
    pmemResp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    waitCommand(seen, cycles);
    checks++;
    if (!seen || cycles != 1 || pmemWrite !== 1'b1 || pmemAddress !== 32'h0000_4440) begin
      errors++;
      $display("[TB] FAIL rst_lastd: cycles %0d wr %b addr %h want 1 1 00004440", cycles, pmemWrite, pmemAddress);
    end
    pmemResp = 1'b1;
    @(negedge clk);
    pmemResp = 1'b0; dWrite = 1'b0;
    waitCommand(seen, cycles);
    checks++;
    if (!seen || pmemRead !== 1'b1 || pmemAddress !== 32'h0000_5550) begin
      errors++;
      $display("[TB] FAIL rst_then_i: rd %b addr %h want 1 00005550", pmemRead, pmemAddress);
    end
    pmemResp = 1'b1;
    @(negedge clk);
    clearInputs();
  endtask

  task test_stray_resp;
    bit seen; int cycles;
    logic [LW-1:0] wd;
    doReset();
    @(negedge clk);
    pmemResp = 1'b1; pmemRdata = randLine();
    #1;
    checks++;
    if ({iResp, dResp} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL stray_resp: iresp %b dresp %b want 0 0", iResp, dResp);
    end
    @(negedge clk);
    pmemResp = 1'b0;
    #1;
    checks++;
    if ({pmemRead, pmemWrite} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL stray_cmd: rd %b wr %b want 0 0", pmemRead, pmemWrite);
    end
    wd = randLine();
    dRead = 1'b1; dWrite = 1'b1; dAddress = 32'h0000_7700; dWdata = wd;
    waitCommand(seen, cycles);
    checks++;
    if (!seen || cycles != 1 || {pmemRead, pmemWrite} !== 2'b01 || pmemWdata !== wd) begin
      errors++;
      $display("[TB] FAIL rw_both: cycles %0d rd %b wr %b wdata %h want 1 0 1 %h", cycles, pmemRead, pmemWrite, pmemWdata, wd);
    end
    pmemResp = 1'b1;
    @(negedge clk);
    clearInputs();
  endtask

  // Reference model: each side is pending or not; a tie goes to the side not
  // served most recently; the served side drops its request after its resp.
  task test_random_traffic;
    bit seen, iPend, dPend, lastD, winD;
    int cycles, kind;
    logic [AW-1:0] eIA, eDA;
    logic eDW;
    logic [LW-1:0] eWd, line;
    doReset();
    iPend = 1'b0; dPend = 1'b0; lastD = 1'b0;
    eIA = '0; eDA = '0; eDW = 1'b0; eWd = '0;
    for (int t = 0; t < 40; t++) begin
      if (!iPend && $urandom_range(0, 1) == 1) begin iPend = 1'b1; eIA = $urandom; end
      if (!dPend && $urandom_range(0, 1) == 1) begin
        dPend = 1'b1; eDA = $urandom; eWd = randLine(); kind = $urandom_range(0, 2);
        eDW = (kind != 0);
        dRead = (kind != 1); dWrite = (kind != 0);
      end
      if (!iPend && !dPend) begin iPend = 1'b1; eIA = $urandom; end
      iRead = iPend; iAddress = eIA;
      if (!dPend) begin dRead = 1'b0; dWrite = 1'b0; end
      dAddress = eDA; dWdata = eWd;
      winD = (iPend && dPend) ? !lastD : dPend;
      waitCommand(seen, cycles);
      checks++;
      if (!seen) begin
        errors++;
        $display("[TB] FAIL rand_timeout_%0d: no command within %0d cycles", t, cycles);
        break;
      end
      checks++;
      if (winD ? ({pmemRead, pmemWrite, pmemAddress} !== {~eDW, eDW, eDA} || (eDW && pmemWdata !== eWd))
               : ({pmemRead, pmemWrite, pmemAddress} !== {2'b10, eIA})) begin
        errors++;
        $display("[TB] FAIL rand_cmd_%0d: rd %b wr %b addr %h want D=%0d dw %b ia %h da %h", t, pmemRead, pmemWrite, pmemAddress, winD, eDW, eIA, eDA);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      line = randLine();
      pmemRdata = line; pmemResp = 1'b1;
      #1;
      checks++;
      if ({dResp, iResp} !== {winD, ~winD} || (winD ? dRdata : iRdata) !== line) begin
        errors++;
        $display("[TB] FAIL rand_resp_%0d: dresp %b iresp %b want D=%0d", t, dResp, iResp, winD);
      end
      @(negedge clk);
      pmemResp = 1'b0;
      if (winD) dPend = 1'b0; else iPend = 1'b0;
      lastD = winD;
    end
    clearInputs();
  endtask

  initial begin
    $display("[TB] cache_arbiter bench start");
    test_reset();
    test_lone_i_read();
    test_lone_d_write();
    test_both_from_reset();
    test_back_to_back();
    test_addr_change();
    test_reset_mid_serve();
    test_stray_resp();
    test_random_traffic();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
